// File: rtl/mux_key.sv
// mux_key: parameterised key/value lookup multiplexer.
// The first LUT entry (lowest index, most significant in the packed vector)
// whose key matches the select key drives the output. default_out is used
// when nothing matches. A one-cycle registered copy is provided for pipelined
// consumers.
module mux_key #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [KEY_LEN-1:0]                     key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
  input  logic [DATA_LEN-1:0]                    default_out,
  input  logic                                   en_i,
  output logic [DATA_LEN-1:0]                    out,
  output logic                                   hit,
  output logic [DATA_LEN-1:0]                    out_q,
  output logic                                   hit_q
);

  localparam int PAIR = KEY_LEN + DATA_LEN;

  if (NR_KEY < 1) begin : g_bad_nr_key
    $error("mux_key: NR_KEY must be >= 1");
  end
  if (KEY_LEN < 1) begin : g_bad_key_len
    $error("mux_key: KEY_LEN must be >= 1");
  end
  if (DATA_LEN < 1) begin : g_bad_data_len
    $error("mux_key: DATA_LEN must be >= 1");
  end

  logic [KEY_LEN-1:0]  lut_key  [NR_KEY];
  logic [DATA_LEN-1:0] lut_data [NR_KEY];

  // Entry 0 sits at the top of the packed vector; key above data in each slice.
  for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_unpack
    assign lut_key[gi]  = lut[(NR_KEY-gi)*PAIR-1 -: KEY_LEN];
    assign lut_data[gi] = lut[(NR_KEY-gi)*PAIR-1-KEY_LEN -: DATA_LEN];
  end

  logic [DATA_LEN-1:0] out_d;
  logic                hit_d;

  // Priority lookup: scan from the last entry down so the lowest index wins.
  always_comb begin
    out_d = default_out;
    hit_d = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (lut_key[i] == key) begin
        out_d = lut_data[i];
        hit_d = 1'b1;
      end
    end
  end

  assign out = out_d;
  assign hit = hit_d;

  // Registered copy of the lookup, loaded when en_i is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else if (en_i) begin
      out_q <= out_d;
      hit_q <= hit_d;
    end
  end

endmodule

// File: tb/tb_mux_key.sv
// tb_mux_key: directed bench for mux_key across four parameterisations
// (lane select, wide miss/default, duplicate-key priority, single entry),
// plus hand-written sequences for the registered stage and async reset.
module tb_mux_key;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Lane select: 4 entries, 2-bit key, 8-bit data.
  logic [1:0]  lane_key = '0;
  logic [7:0]  lane_dflt = '0;
  logic        lane_en = 1'b0;
  logic [7:0]  lane_out, lane_out_q;
  logic        lane_hit, lane_hit_q;
  wire  [39:0] lane_lut = {2'b00, 8'hAA, 2'b01, 8'hBB, 2'b10, 8'hCC, 2'b11, 8'hDD};

  // Miss/default: 4 entries, 3-bit key, 32-bit data.
  logic [2:0]   miss_key = '0;
  logic [31:0]  miss_dflt = '0;
  logic         miss_en = 1'b0;
  logic [31:0]  miss_out, miss_out_q;
  logic         miss_hit, miss_hit_q;
  wire  [139:0] miss_lut = {3'd0, 32'h1111_0000, 3'd1, 32'h2222_0001,
                            3'd2, 32'h3333_0002, 3'd3, 32'h4444_0003};

  // Priority: 3 entries with a duplicated key.
  logic [1:0]  pri_key = '0;
  logic [7:0]  pri_dflt = '0;
  logic        pri_en = 1'b0;
  logic [7:0]  pri_out, pri_out_q;
  logic        pri_hit, pri_hit_q;
  wire  [29:0] pri_lut = {2'b01, 8'h11, 2'b01, 8'h22, 2'b10, 8'h33};

  // Degenerate: single entry.
  logic [0:0]  deg_key = '0;
  logic [3:0]  deg_dflt = '0;
  logic        deg_en = 1'b0;
  logic [3:0]  deg_out, deg_out_q;
  logic        deg_hit, deg_hit_q;
  wire  [4:0]  deg_lut = {1'b1, 4'h9};

  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_lane (
    .clk_i(clk), .rst_ni(rst_n), .key(lane_key), .lut(lane_lut),
    .default_out(lane_dflt), .en_i(lane_en), .out(lane_out), .hit(lane_hit),
    .out_q(lane_out_q), .hit_q(lane_hit_q));

  mux_key #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(32)) u_miss (
    .clk_i(clk), .rst_ni(rst_n), .key(miss_key), .lut(miss_lut),
    .default_out(miss_dflt), .en_i(miss_en), .out(miss_out), .hit(miss_hit),
    .out_q(miss_out_q), .hit_q(miss_hit_q));

  mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(8)) u_pri (
    .clk_i(clk), .rst_ni(rst_n), .key(pri_key), .lut(pri_lut),
    .default_out(pri_dflt), .en_i(pri_en), .out(pri_out), .hit(pri_hit),
    .out_q(pri_out_q), .hit_q(pri_hit_q));

  mux_key #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(4)) u_deg (
    .clk_i(clk), .rst_ni(rst_n), .key(deg_key), .lut(deg_lut),
    .default_out(deg_dflt), .en_i(deg_en), .out(deg_out), .hit(deg_hit),
    .out_q(deg_out_q), .hit_q(deg_hit_q));

  typedef struct {
    int          dut;
    logic [31:0] key;
    logic [31:0] dflt;
    logic [31:0] eout;
    logic        ehit;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] got_out;
    logic        got_hit;

    vecs[0]  = '{0, 32'd0, 32'h0,        32'hAA,        1'b1};
    vecs[1]  = '{0, 32'd1, 32'h0,        32'hBB,        1'b1};
    vecs[2]  = '{0, 32'd2, 32'h0,        32'hCC,        1'b1};
    vecs[3]  = '{0, 32'd3, 32'h0,        32'hDD,        1'b1};
    vecs[4]  = '{1, 32'd5, 32'h0,        32'h0,         1'b0};
    vecs[5]  = '{1, 32'd5, 32'hDEADBEEF, 32'hDEADBEEF,  1'b0};
    vecs[6]  = '{1, 32'd2, 32'hDEADBEEF, 32'h3333_0002, 1'b1};
    vecs[7]  = '{1, 32'd7, 32'h0,        32'h0,         1'b0};
    vecs[8]  = '{2, 32'd1, 32'h5A,       32'h11,        1'b1};
    vecs[9]  = '{2, 32'd2, 32'h5A,       32'h33,        1'b1};
    vecs[10] = '{2, 32'd0, 32'h5A,       32'h5A,        1'b0};
    vecs[11] = '{3, 32'd1, 32'h6,        32'h9,         1'b1};
    vecs[12] = '{3, 32'd0, 32'h6,        32'h6,         1'b0};
    vecs[13] = '{3, 32'd0, 32'h0,        32'h0,         1'b0};

    // Reset state of the registered stage.
    #2 rst_n = 1'b0;
    #2;
    check("reset lane out_q", {24'h0, lane_out_q}, 32'h0);
    check("reset lane hit_q", {31'h0, lane_hit_q}, 32'h0);
    check("reset miss out_q", miss_out_q, 32'h0);

    // Combinational lookups, all parameterisations.
    for (int i = 0; i < 14; i++) begin
      case (vecs[i].dut)
        0: begin lane_key = vecs[i].key[1:0]; lane_dflt = vecs[i].dflt[7:0]; end
        1: begin miss_key = vecs[i].key[2:0]; miss_dflt = vecs[i].dflt; end
        2: begin pri_key  = vecs[i].key[1:0]; pri_dflt  = vecs[i].dflt[7:0]; end
        default: begin deg_key = vecs[i].key[0:0]; deg_dflt = vecs[i].dflt[3:0]; end
      endcase
      #1;
      case (vecs[i].dut)
        0: begin got_out = {24'h0, lane_out}; got_hit = lane_hit; end
        1: begin got_out = miss_out;          got_hit = miss_hit; end
        2: begin got_out = {24'h0, pri_out};  got_hit = pri_hit; end
        default: begin got_out = {28'h0, deg_out}; got_hit = deg_hit; end
      endcase
      check($sformatf("vec%0d out", i), got_out, vecs[i].eout);
      check($sformatf("vec%0d hit", i), {31'h0, got_hit}, {31'h0, vecs[i].ehit});
    end

    // Registers hold at zero while reset is low even with en_i high.
    lane_en = 1'b1;
    lane_key = 2'd1;
    @(posedge clk); #1;
    check("reset hold out_q", {24'h0, lane_out_q}, 32'h0);

    // Release away from an edge, capture key=2.
    @(negedge clk);
    rst_n = 1'b1;
    lane_key = 2'd2;
    @(posedge clk); #1;
    check("reg load out_q", {24'h0, lane_out_q}, 32'hCC);
    check("reg load hit_q", {31'h0, lane_hit_q}, 32'h1);

    // en_i low: registered path holds while comb follows.
    lane_en = 1'b0;
    lane_key = 2'd3;
    @(posedge clk); #1;
    check("reg hold out_q", {24'h0, lane_out_q}, 32'hCC);
    check("reg hold hit_q", {31'h0, lane_hit_q}, 32'h1);
    check("comb while hold", {24'h0, lane_out}, 32'hDD);

    // Async reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_q", {24'h0, lane_out_q}, 32'h0);
    check("async rst hit_q", {31'h0, lane_hit_q}, 32'h0);
    check("comb in reset out", {24'h0, lane_out}, 32'hDD);
    check("comb in reset hit", {31'h0, lane_hit}, 32'h1);

    // Release and reload with the current lookup.
    #1 rst_n = 1'b1;
    lane_en = 1'b1;
    @(posedge clk); #1;
    check("reload out_q", {24'h0, lane_out_q}, 32'hDD);
    check("reload hit_q", {31'h0, lane_hit_q}, 32'h1);

    // Registered miss on the wide instance captures default and hit=0.
    miss_key = 3'd6;
    miss_dflt = 32'hCAFE_F00D;
    miss_en = 1'b1;
    @(posedge clk); #1;
    check("miss out_q", miss_out_q, 32'hCAFE_F00D);
    check("miss hit_q", {31'h0, miss_hit_q}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_key.md
Name: mux_key

Overview:
- Generic parameterised key/value lookup multiplexer.
- Output is the data word paired with the first LUT entry whose key equals the select key.
- Used throughout the core for byte/half-word lane selection, load extension select and store data/strobe generation.
- Provides a combinational result path and a one-cycle registered copy for pipelined consumers.

Parameters:
- NR_KEY, 2, number of key/data pairs in the LUT (≥1).
- KEY_LEN, 1, width of each key and of the select input (≥1).
- DATA_LEN, 1, width of each data word and of the outputs (≥1).

Ports:
- clk_i  input  1  clock; registered path samples on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- key  input  KEY_LEN  select key.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed key/data pairs.
- default_out  input  DATA_LEN  value driven when no entry matches; tie to 0 for plain-mux use.
- en_i  input  1  load enable for the registered stage.
- out  output  DATA_LEN  combinational lookup result.
- hit  output  1  combinational: at least one key matched.
- out_q  output  DATA_LEN  registered out.
- hit_q  output  1  registered hit.

Behaviour:
- Define PAIR = KEY_LEN+DATA_LEN.
- LUT packing: callers write pairs as a concatenation {k0,d0,k1,d1,...}, so entry 0 is most significant.
  - Entry i occupies lut[(NR_KEY-i)*PAIR-1 -: PAIR].
  - Within that slice, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
- Match: entry i matches when its key equals key bit-exactly.
  - X/Z on key or lut propagates per normal simulation semantics; no special handling.
- Priority: if several entries match, the lowest index wins (the first one written in the concatenation).
- out = data of the winning entry, else default_out.
- hit = OR of all matches.
- out and hit are purely combinational: zero latency, independent of clk_i and rst_ni.
- Registered stage:
  - rst_ni low (asynchronous, any time, including mid-operation): out_q = 0 and hit_q = 0 immediately. They hold while reset is low.
  - On a rising clk_i with rst_ni high and en_i = 1: out_q <= out and hit_q <= hit.
  - With en_i = 0: out_q and hit_q hold.
- Reset deassertion is not required to be synchronised inside the block; the first capture happens at the first rising edge after deassertion with en_i high.
- Reset values of the outputs:
  - out_q = 0, hit_q = 0.
  - out and hit follow the inputs even during reset.
- NR_KEY = 1 is legal: a single compare; out = d0 if key == k0, else default_out.
- KEY_LEN may be less than the number of bits needed to enumerate NR_KEY entries; duplicate keys are legal and resolved by priority.
- Elaboration checks: NR_KEY, KEY_LEN and DATA_LEN must each be ≥1. Violations produce an elaboration-time error.

Test Plan:
- Lane select: NR_KEY=4, KEY_LEN=2, DATA_LEN=8, lut={2'b00,8'hAA,2'b01,8'hBB,2'b10,8'hCC,2'b11,8'hDD}. Sweep key 0..3 -> out = AA, BB, CC, DD; hit = 1 for every key.
- Miss/default: NR_KEY=4, KEY_LEN=3, DATA_LEN=32, keys {0,1,2,3}, default_out = 0. key = 3'b101 -> out = 0, hit = 0. Repeat with default_out = 32'hDEADBEEF -> out = DEADBEEF, hit = 0.
- Priority: NR_KEY=3, keys {2'b01, 2'b01, 2'b10}, data {8'h11, 8'h22, 8'h33}. key = 01 -> out = 11 (entry 0 wins); key = 10 -> out = 33.
- Registered path: with en_i = 1, apply key = 2 and clock -> out_q = CC, hit_q = 1 after the edge. Then set en_i = 0, change key to 3 and clock -> out_q stays CC while out = DD.
- Async reset mid-operation: with out_q = CC, pull rst_ni low between clock edges -> out_q = 0 and hit_q = 0 without waiting for an edge. Release, hold en_i = 1 and clock -> out_q reloads with the current out.
- Degenerate: NR_KEY=1, KEY_LEN=1, DATA_LEN=4, lut={1'b1, 4'h9}. key = 1 -> out = 9, hit = 1. key = 0 -> out = default_out, hit = 0.
